// File: rtl/nrzi_decode_rx.sv
// nrzi_decode_rx: USB full-speed receive front end. Samples the differential line once per bit
// time, locks onto SYNC (K J K J K J K K), NRZI-decodes the packet body into a serial bit stream
// framed by nrzi_sending, and detects EOP (SE0, SE0, J) and line errors.
// Optional build macro NRZI_RX_BABBLE_EN: abort a packet whose length would exceed MAX_BITS.
// All outputs are registered; a line sample taken at edge n is reflected after edge n.

module nrzi_decode_rx #(
    parameter int unsigned IDLE_J   = 8,
    parameter int unsigned MAX_BITS = 1100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dp_in,
    input  logic        dm_in,
    output logic        nrzi_sending,
    output logic        out_bit,
    output logic        eop_seen,
    output logic        rx_err,
    output logic [15:0] bit_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_EOP1  = 3'd3;
    localparam logic [2:0] ST_EOP2  = 3'd4;
    localparam logic [2:0] ST_ABORT = 3'd5;

    // Bit i set means SYNC symbol i is K: K J K J K J K K.
    localparam logic [7:0] SYNC_PAT = 8'b1101_0101;

`ifdef NRZI_RX_BABBLE_EN
    localparam bit BABBLE_EN = 1'b1;
`else
    localparam bit BABBLE_EN = 1'b0;
`endif

    logic [2:0]  r_state;
    logic [2:0]  r_sync_idx;
    logic [15:0] r_j_cnt;
    logic        r_prev_j;      // previous data symbol: 1 = J, 0 = K
    logic        r_sending;
    logic        r_out_bit;
    logic        r_eop;
    logic        r_err;
    logic [15:0] r_bit_cnt;

    logic [2:0]  w_state_nxt;
    logic [2:0]  w_sync_idx_nxt;
    logic [15:0] w_j_cnt_nxt;
    logic        w_prev_j_nxt;
    logic        w_sending_nxt;
    logic        w_out_bit_nxt;
    logic        w_eop_nxt;
    logic        w_err_nxt;
    logic [15:0] w_bit_cnt_nxt;

    logic w_is_j;
    logic w_is_k;
    logic w_is_se0;
    logic w_sync_match;
    logic w_at_max;
    logic w_abort_done;

    assign w_is_j       = dp_in & ~dm_in;
    assign w_is_k       = ~dp_in & dm_in;
    assign w_is_se0     = ~dp_in & ~dm_in;
    assign w_sync_match = SYNC_PAT[r_sync_idx] ? w_is_k : w_is_j;
    // Constant-folds to 0 when the length limit is not built in.
    assign w_at_max     = BABBLE_EN && ({16'd0, r_bit_cnt} >= MAX_BITS);
    assign w_abort_done = (32'(r_j_cnt) + 32'd1) >= IDLE_J;

    // Next-state and registered-output decode for the receive state machine.
    always_comb begin
        w_state_nxt    = r_state;
        w_sync_idx_nxt = r_sync_idx;
        w_j_cnt_nxt    = r_j_cnt;
        w_prev_j_nxt   = r_prev_j;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_sending_nxt  = 1'b0;
        w_out_bit_nxt  = 1'b0;
        w_eop_nxt      = 1'b0;
        w_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_is_k) begin
                    w_state_nxt    = ST_SYNC;
                    w_sync_idx_nxt = 3'd1;
                    w_bit_cnt_nxt  = 16'd0;
                end else if (dp_in && dm_in) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_ABORT;
                    w_j_cnt_nxt = 16'd0;
                end
            end
            ST_SYNC: begin
                if (!w_sync_match) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_ABORT;
                    w_j_cnt_nxt = 16'd0;
                end else if (r_sync_idx == 3'd7) begin
                    // First data bit is decoded against the final SYNC K.
                    w_state_nxt    = ST_DATA;
                    w_prev_j_nxt   = 1'b0;
                    w_sync_idx_nxt = 3'd0;
                end else begin
                    w_sync_idx_nxt = r_sync_idx + 3'd1;
                end
            end
            ST_DATA: begin
                if (w_is_j || w_is_k) begin
                    if (w_at_max) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_ABORT;
                        w_j_cnt_nxt = 16'd0;
                    end else begin
                        // No transition decodes as 1; stuffed bits pass through untouched.
                        w_sending_nxt = 1'b1;
                        w_out_bit_nxt = (dp_in == r_prev_j);
                        w_prev_j_nxt  = dp_in;
                        w_bit_cnt_nxt = (r_bit_cnt == 16'hFFFF) ? r_bit_cnt
                                                                : r_bit_cnt + 16'd1;
                    end
                end else if (w_is_se0) begin
                    w_state_nxt = ST_EOP1;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_ABORT;
                    w_j_cnt_nxt = 16'd0;
                end
            end
            ST_EOP1: begin
                if (w_is_se0) begin
                    w_state_nxt = ST_EOP2;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_ABORT;
                    w_j_cnt_nxt = 16'd0;
                end
            end
            ST_EOP2: begin
                if (w_is_j) begin
                    w_eop_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_ABORT;
                    w_j_cnt_nxt = 16'd0;
                end
            end
            ST_ABORT: begin
                // Wait for a run of idle J before trusting the line again.
                if (!w_is_j) begin
                    w_j_cnt_nxt = 16'd0;
                end else if (w_abort_done) begin
                    w_state_nxt = ST_IDLE;
                    w_j_cnt_nxt = 16'd0;
                end else begin
                    w_j_cnt_nxt = r_j_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sync_idx <= 3'd0;
            r_j_cnt    <= 16'd0;
            r_prev_j   <= 1'b1;
            r_sending  <= 1'b0;
            r_out_bit  <= 1'b0;
            r_eop      <= 1'b0;
            r_err      <= 1'b0;
            r_bit_cnt  <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_idx <= w_sync_idx_nxt;
            r_j_cnt    <= w_j_cnt_nxt;
            r_prev_j   <= w_prev_j_nxt;
            r_sending  <= w_sending_nxt;
            r_out_bit  <= w_out_bit_nxt;
            r_eop      <= w_eop_nxt;
            r_err      <= w_err_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
        end
    end

    assign nrzi_sending = r_sending;
    assign out_bit      = r_out_bit;
    assign eop_seen     = r_eop;
    assign rx_err       = r_err;
    assign bit_cnt      = r_bit_cnt;

endmodule

// File: doc/nrzi_decode_rx.md
Name: nrzi_decode_rx

Overview:
- Receive-side front end of the USB full-speed bit pipeline; sits directly upstream of the bit-unstuffing stage.
- Samples differential line state (one sample per bit time), detects the SYNC pattern, and NRZI-decodes the packet body into a serial bit stream.
- Frames the stream with nrzi_sending, which the unstuffer consumes directly with in_bit.
- Detects EOP (SE0, SE0, J) and line errors, then returns to idle.

Parameters:
- IDLE_J, 8: consecutive J samples required to leave ABORT.
- MAX_BITS, 1100: decoded-bit limit for babble detection (used only with the optional feature).

Ports:
- clock  in  1  system clock, one bit time per cycle
- reset  in  1  asynchronous, active-high reset
- dp_in  in  1  sampled D+ line
- dm_in  in  1  sampled D- line
- nrzi_sending  out  1  high while out_bit carries a decoded packet bit
- out_bit  out  1  NRZI-decoded bit; 0 when nrzi_sending is low
- eop_seen  out  1  one-cycle pulse when a valid EOP completes
- rx_err  out  1  one-cycle pulse on SYNC mismatch, bad EOP, SE1 or babble
- bit_cnt  out  16  decoded bits in the current packet; holds until the next SYNC start

Behaviour:
- Line symbols:
  - J = (dp=1, dm=0)
  - K = (dp=0, dm=1)
  - SE0 = (0, 0)
  - SE1 = (1, 1), always illegal
- All outputs are registered.
  - Line sample at edge n appears on the outputs after edge n.
  - Latency is 1 cycle.
- Reset (async, active-high): state=IDLE; nrzi_sending=0, out_bit=0, eop_seen=0, rx_err=0, bit_cnt=0, prev_sym=J, sync_idx=0, j_cnt=0.
- SYNC pattern: K J K J K J K K (index 0..7).
- States:
  - IDLE:
    - J or SE0 -> stay.
    - K -> SYNC, sync_idx=1, bit_cnt=0.
    - SE1 -> rx_err pulse, ABORT.
  - SYNC:
    - Sample equals pattern[sync_idx] -> sync_idx+1.
    - Match at sync_idx=7 -> DATA, prev_sym=K.
    - Mismatch (including SE0/SE1) -> rx_err pulse, ABORT.
    - No bits are emitted during SYNC.
  - DATA:
    - J or K -> nrzi_sending=1, out_bit=(sample==prev_sym), prev_sym=sample, bit_cnt+1 (saturates at 16'hFFFF).
    - SE0 -> EOP1, nrzi_sending=0.
    - SE1 -> rx_err pulse, nrzi_sending=0, ABORT.
  - EOP1:
    - SE0 -> EOP2.
    - Anything else -> rx_err pulse, ABORT.
  - EOP2:
    - J -> eop_seen pulse, IDLE.
    - Anything else -> rx_err pulse, ABORT.
  - ABORT:
    - j_cnt counts consecutive J samples; any non-J clears it.
    - On reaching IDLE_J -> IDLE, j_cnt=0.
- The first DATA bit is decoded against the final SYNC K.
  - Stuffed zeros are forwarded untouched; removal belongs downstream.
- nrzi_sending stays high for every consecutive DATA cycle, with no gaps.
  - It drops on the same edge the first SE0 is processed.
- eop_seen and rx_err are never high in the same cycle.
  - Neither is high while nrzi_sending is high.
- Reset mid-packet: outputs clear immediately (async).
  - The next packet must present a full SYNC.
- A one-sample SE0 inside DATA followed by J/K is a bad EOP: rx_err pulse, ABORT. It is not treated as data.

Optional Feature:
- Macro: NRZI_RX_BABBLE_EN
- Defined:
  - In DATA, when bit_cnt reaches MAX_BITS and another J/K arrives: that bit is not emitted, nrzi_sending=0, rx_err pulse, ABORT.
- Undefined:
  - No length limit; bit_cnt only saturates; MAX_BITS is unused.

Test Plan:
- Idle J x10, then SYNC KJKJKJKK, then K,K,J,J,SE0,SE0,J -> out_bit 1,1,0,1 with nrzi_sending high for exactly 4 cycles; eop_seen pulses 1 cycle after the J; bit_cnt=4.
- SYNC with 5th symbol K instead of K->J error (K J K J K K) -> rx_err pulse at the mismatched sample, no nrzi_sending; then J x8 -> returns to IDLE; a following valid packet decodes correctly.
- Packet body of 7 samples all K after SYNC -> out_bit 1,1,1,1,1,1,1 (stuff-violation pattern passed unmodified); then EOP -> eop_seen.
- DATA then SE0, K -> rx_err pulse; nrzi_sending low from the SE0 cycle; eop_seen never asserts.
- SE1 during DATA -> rx_err 1 cycle later, nrzi_sending low; async reset asserted mid-DATA -> all outputs 0 immediately, state IDLE.
- With NRZI_RX_BABBLE_EN and MAX_BITS=16: SYNC plus 20 data symbols -> exactly 16 bits emitted, rx_err pulse on the 17th, no eop_seen.
